// File: rtl/decode_pkg.sv
// Shared decode types: opcode constants, format enum, decoded bundle.
// Imported by decode_comb and decode_stage.
package decode_pkg;

  localparam logic [6:0] OPC_OP     = 7'h33;
  localparam logic [6:0] OPC_OPIMM  = 7'h13;
  localparam logic [6:0] OPC_LOAD   = 7'h03;
  localparam logic [6:0] OPC_STORE  = 7'h23;
  localparam logic [6:0] OPC_BRANCH = 7'h63;
  localparam logic [6:0] OPC_JAL    = 7'h6f;
  localparam logic [6:0] OPC_JALR   = 7'h67;
  localparam logic [6:0] OPC_LUI    = 7'h37;
  localparam logic [6:0] OPC_AUIPC  = 7'h17;

  // Immediate is built at the widest legal XLEN and truncated by users.
  localparam int IMM_W = 64;

  typedef enum logic [2:0] {
    FMT_R,
    FMT_I,
    FMT_S,
    FMT_B,
    FMT_U,
    FMT_J,
    FMT_ILLEGAL
  } fmt_e;

  typedef struct packed {
    fmt_e             fmt;
    logic             illegal;
    logic [4:0]       rs1;
    logic [4:0]       rs2;
    logic [4:0]       rd;
    logic [2:0]       funct3;
    logic [6:0]       funct7;
    logic [IMM_W-1:0] imm;
  } dec_t;

endpackage

// File: rtl/decode_comb.sv
// Combinational RV32I field decode: instr -> dec_t.
// Ports: instr (32-bit word in), dec (decoded bundle out).
module decode_comb
  import decode_pkg::*;
(
  input  logic [31:0] instr,
  output dec_t        dec
);

  logic [6:0] opc;
  logic [6:0] f7;
  logic       r_ok;
  logic       i_ok;
  logic       s_ok;
  logic       b_ok;
  logic       u_ok;
  logic       j_ok;
  logic [IMM_W-1:0] sx;

  assign opc = instr[6:0];
  assign f7  = instr[31:25];
  assign sx  = {IMM_W{instr[31]}};

  // Every legal opcode ends in 2'b11, so a bad
  // low pair simply matches nothing below.
  assign r_ok = (opc == OPC_OP) &&
                (f7 == 7'h00 || f7 == 7'h20 ||
                 f7 == 7'h01);
  assign i_ok = (opc == OPC_OPIMM) ||
                (opc == OPC_LOAD) ||
                (opc == OPC_JALR);
  assign s_ok = (opc == OPC_STORE);
  assign b_ok = (opc == OPC_BRANCH);
  assign u_ok = (opc == OPC_LUI) ||
                (opc == OPC_AUIPC);
  assign j_ok = (opc == OPC_JAL);

  always_comb begin
    dec         = '0;
    dec.fmt     = FMT_ILLEGAL;
    dec.illegal = 1'b1;
    unique case (1'b1)
      r_ok: begin
        dec.fmt     = FMT_R;
        dec.illegal = 1'b0;
        dec.rs1     = instr[19:15];
        dec.rs2     = instr[24:20];
        dec.rd      = instr[11:7];
        dec.funct3  = instr[14:12];
        dec.funct7  = f7;
      end
      i_ok: begin
        dec.fmt     = FMT_I;
        dec.illegal = 1'b0;
        dec.rs1     = instr[19:15];
        dec.rd      = instr[11:7];
        dec.funct3  = instr[14:12];
        dec.imm     = {sx[IMM_W-1:12],
                       instr[31:20]};
      end
      s_ok: begin
        dec.fmt     = FMT_S;
        dec.illegal = 1'b0;
        dec.rs1     = instr[19:15];
        dec.rs2     = instr[24:20];
        dec.funct3  = instr[14:12];
        dec.imm     = {sx[IMM_W-1:12],
                       instr[31:25],
                       instr[11:7]};
      end
      b_ok: begin
        dec.fmt     = FMT_B;
        dec.illegal = 1'b0;
        dec.rs1     = instr[19:15];
        dec.rs2     = instr[24:20];
        dec.funct3  = instr[14:12];
        dec.imm     = {sx[IMM_W-1:13],
                       instr[31], instr[7],
                       instr[30:25],
                       instr[11:8], 1'b0};
      end
      u_ok: begin
        dec.fmt     = FMT_U;
        dec.illegal = 1'b0;
        dec.rd      = instr[11:7];
        dec.imm     = {sx[IMM_W-1:32],
                       instr[31:12], 12'b0};
      end
      j_ok: begin
        dec.fmt     = FMT_J;
        dec.illegal = 1'b0;
        dec.rd      = instr[11:7];
        dec.imm     = {sx[IMM_W-1:21],
                       instr[31],
                       instr[19:12],
                       instr[20],
                       instr[30:21], 1'b0};
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/decode_stage.sv
// Decode pipeline stage: 1-cycle latency, output reg plus one skid entry.
// Ports: clk, rst_n, flush; in_valid/in_ready/in_instr/in_pc upstream;
// out_valid/out_ready/out_pc/out_rs1/out_rs2/out_rd/out_funct3/out_funct7
// /out_imm/out_fmt/out_illegal downstream. Macro DECODE_PERF_CNT_EN adds
// saturating dec_count/ill_count performance counters.
module decode_stage
  import decode_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int CNT_W = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  input  logic [XLEN-1:0] in_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_pc,
  output logic [4:0]      out_rs1,
  output logic [4:0]      out_rs2,
  output logic [4:0]      out_rd,
  output logic [2:0]      out_funct3,
  output logic [6:0]      out_funct7,
  output logic [XLEN-1:0] out_imm,
  output logic [2:0]      out_fmt,
  output logic            out_illegal
`ifdef DECODE_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0] dec_count,
  output logic [CNT_W-1:0] ill_count
`endif
);

  dec_t            dec_in;
  dec_t            out_q;
  dec_t            skid_q;
  logic [XLEN-1:0] out_pc_q;
  logic [XLEN-1:0] skid_pc;
  logic            out_v;
  logic            skid_v;
  logic            rdy_q;
  logic            in_fire;
  logic            out_fire;
  logic            unused_imm;

  decode_comb u_dec (
    .instr (in_instr),
    .dec   (dec_in)
  );

  assign in_fire  = in_valid && rdy_q;
  assign out_fire = out_v && out_ready;

  // rdy_q mirrors !skid_v but is its own flop
  // so in_ready comes straight from a register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_v    <= 1'b0;
      skid_v   <= 1'b0;
      rdy_q    <= 1'b1;
      out_q    <= '0;
      skid_q   <= '0;
      out_pc_q <= '0;
      skid_pc  <= '0;
    end else if (flush) begin
      out_v  <= 1'b0;
      skid_v <= 1'b0;
      rdy_q  <= 1'b1;
    end else if (!out_v || out_ready) begin
      if (skid_v) begin
        out_q    <= skid_q;
        out_pc_q <= skid_pc;
        out_v    <= 1'b1;
        skid_v   <= 1'b0;
        rdy_q    <= 1'b1;
      end else if (in_fire) begin
        out_q    <= dec_in;
        out_pc_q <= in_pc;
        out_v    <= 1'b1;
      end else begin
        out_v <= 1'b0;
      end
    end else if (in_fire) begin
      skid_q  <= dec_in;
      skid_pc <= in_pc;
      skid_v  <= 1'b1;
      rdy_q   <= 1'b0;
    end
  end

  assign in_ready    = rdy_q;
  assign out_valid   = out_v;
  assign out_pc      = out_pc_q;
  assign out_rs1     = out_q.rs1;
  assign out_rs2     = out_q.rs2;
  assign out_rd      = out_q.rd;
  assign out_funct3  = out_q.funct3;
  assign out_funct7  = out_q.funct7;
  assign out_imm     = out_q.imm[XLEN-1:0];
  assign out_fmt     = out_q.fmt;
  assign out_illegal = out_q.illegal;

  // Upper immediate bits are dropped when XLEN=32.
  assign unused_imm = ^{out_q.imm, skid_v};

`ifdef DECODE_PERF_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dec_count <= '0;
      ill_count <= '0;
    end else if (out_fire) begin
      if (dec_count != {CNT_W{1'b1}})
        dec_count <= dec_count + 1'b1;
      if (out_q.illegal &&
          ill_count != {CNT_W{1'b1}})
        ill_count <= ill_count + 1'b1;
    end
  end
`else
  logic [CNT_W-1:0] unused_cnt;
  assign unused_cnt = {CNT_W{out_fire}};
`endif

endmodule
